// File: rtl/tank_turn_sequencer.sv
// Turn scheduler for the two-player tank game: arbitrates moves, launch, shell flight,
// damage and the turn hand-over between the two tanks in one explicit FSM.
module tank_turn_sequencer #(
    parameter int unsigned TURN_TIMEOUT   = 4096,
    parameter int unsigned MOVE_COOLDOWN  = 64,
    parameter int unsigned MOVES_PER_TURN = 3,
    parameter int unsigned FLIGHT_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_4,
    input  logic       key_6,
    input  logic       key_5,
    input  logic [1:0] power_in,
    input  logic       shell_busy,
    input  logic       hit,
    input  logic [1:0] tank1_life,
    input  logic [1:0] tank2_life,
    output logic       turn,
    output logic       move_right,
    output logic       move_left,
    output logic       fire_start,
    output logic [1:0] power_q,
    output logic       dmg_tank1,
    output logic       dmg_tank2,
    output logic [1:0] moves_left,
    output logic [2:0] state,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam int unsigned TW = (TURN_TIMEOUT   > 1) ? $clog2(TURN_TIMEOUT)   : 1;
    localparam int unsigned CW = (MOVE_COOLDOWN  > 1) ? $clog2(MOVE_COOLDOWN)  : 1;
    localparam int unsigned FW = (FLIGHT_TIMEOUT > 1) ? $clog2(FLIGHT_TIMEOUT) : 1;

    localparam logic [TW-1:0] TURN_LAST   = TW'(TURN_TIMEOUT - 1);
    localparam logic [CW-1:0] COOL_LOAD   = CW'(MOVE_COOLDOWN - 1);
    localparam logic [FW-1:0] FLIGHT_LAST = FW'(FLIGHT_TIMEOUT - 1);
    localparam logic [1:0]    MOVES_INIT  = 2'(MOVES_PER_TURN);

    typedef enum logic [2:0] {
        S_MOVE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_FLIGHT  = 3'd2,
        S_RESOLVE = 3'd3,
        S_SWAP    = 3'd4,
        S_OVER    = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic          turn_q, turn_d;
    logic [1:0]    moves_q, moves_d;
    logic [CW-1:0] cool_q, cool_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [FW-1:0] flight_q, flight_d;
    logic          saw_busy_q, saw_busy_d;
    logic [1:0]    power_r, power_d;
    logic          mr_q, mr_d, ml_q, ml_d, fs_q, fs_d;
    logic          d1_q, d1_d, d2_q, d2_d;
    logic          over_q, over_d;
    logic [1:0]    win_q, win_d;
    logic          prev4_q, prev6_q, prev5_q;
    logic          e4, e6, e5;

    assign e4 = key_4 & ~prev4_q;
    assign e6 = key_6 & ~prev6_q;
    assign e5 = key_5 & ~prev5_q;

    always_comb begin
        state_d    = state_q;
        turn_d     = turn_q;
        moves_d    = moves_q;
        cool_d     = (cool_q != '0) ? cool_q - CW'(1) : '0;
        timer_d    = timer_q;
        flight_d   = flight_q;
        saw_busy_d = saw_busy_q;
        power_d    = power_r;
        mr_d       = 1'b0;
        ml_d       = 1'b0;
        fs_d       = 1'b0;
        d1_d       = 1'b0;
        d2_d       = 1'b0;
        over_d     = over_q;
        win_d      = win_q;

        case (state_q)
            S_MOVE: begin
                if (timer_q != TURN_LAST)
                    timer_d = timer_q + TW'(1);
                // Strobe and power are registered on LAUNCH entry so they line up with the state
                if (e5 || timer_q == TURN_LAST) begin
                    state_d = S_LAUNCH;
                    fs_d    = 1'b1;
                    power_d = power_in;
                end else if ((e4 || e6) && moves_q != '0 && cool_q == '0) begin
                    mr_d    = e4;
                    ml_d    = ~e4;
                    moves_d = moves_q - 2'd1;
                    cool_d  = COOL_LOAD;
                end
            end
            S_LAUNCH: begin
                flight_d   = '0;
                saw_busy_d = 1'b0;
                state_d    = S_FLIGHT;
            end
            S_FLIGHT: begin
                if (shell_busy)
                    saw_busy_d = 1'b1;
                // Damage strobe issued on RESOLVE entry so it is visible during RESOLVE
                if (saw_busy_q && !shell_busy) begin
                    state_d = S_RESOLVE;
                    d1_d    = hit & turn_q;
                    d2_d    = hit & ~turn_q;
                end else if (!saw_busy_q && flight_q == FLIGHT_LAST) begin
                    state_d = S_RESOLVE;
                end else if (flight_q != FLIGHT_LAST) begin
                    flight_d = flight_q + FW'(1);
                end
            end
            S_RESOLVE: begin
                state_d = S_SWAP;
            end
            S_SWAP: begin
                if (tank1_life == 2'd0) begin
                    win_d   = 2'd2;
                    over_d  = 1'b1;
                    state_d = S_OVER;
                end else if (tank2_life == 2'd0) begin
                    win_d   = 2'd1;
                    over_d  = 1'b1;
                    state_d = S_OVER;
                end else begin
                    turn_d  = ~turn_q;
                    moves_d = MOVES_INIT;
                    timer_d = '0;
                    cool_d  = '0;
                    state_d = S_MOVE;
                end
            end
            S_OVER: begin
                over_d = 1'b1;
            end
            default: begin
                state_d    = S_MOVE;
                turn_d     = 1'b0;
                moves_d    = MOVES_INIT;
                cool_d     = '0;
                timer_d    = '0;
                flight_d   = '0;
                saw_busy_d = 1'b0;
                power_d    = '0;
                over_d     = 1'b0;
                win_d      = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_MOVE;
            turn_q     <= 1'b0;
            moves_q    <= MOVES_INIT;
            cool_q     <= '0;
            timer_q    <= '0;
            flight_q   <= '0;
            saw_busy_q <= 1'b0;
            power_r    <= '0;
            mr_q       <= 1'b0;
            ml_q       <= 1'b0;
            fs_q       <= 1'b0;
            d1_q       <= 1'b0;
            d2_q       <= 1'b0;
            over_q     <= 1'b0;
            win_q      <= '0;
            prev4_q    <= 1'b1;
            prev6_q    <= 1'b1;
            prev5_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            turn_q     <= turn_d;
            moves_q    <= moves_d;
            cool_q     <= cool_d;
            timer_q    <= timer_d;
            flight_q   <= flight_d;
            saw_busy_q <= saw_busy_d;
            power_r    <= power_d;
            mr_q       <= mr_d;
            ml_q       <= ml_d;
            fs_q       <= fs_d;
            d1_q       <= d1_d;
            d2_q       <= d2_d;
            over_q     <= over_d;
            win_q      <= win_d;
            prev4_q    <= key_4;
            prev6_q    <= key_6;
            prev5_q    <= key_5;
        end
    end

    assign turn       = turn_q;
    assign move_right = mr_q;
    assign move_left  = ml_q;
    assign fire_start = fs_q;
    assign power_q    = power_r;
    assign dmg_tank1  = d1_q;
    assign dmg_tank2  = d2_q;
    assign moves_left = moves_q;
    assign state      = state_q;
    assign game_over  = over_q;
    assign winner     = win_q;

endmodule

// File: tb/tb_tank_turn_sequencer.sv
// Directed bench for tank_turn_sequencer: moves, cooldown, fire/flight/damage,
// forced fire, miss timeout, game over and reset abort.
module tb_tank_turn_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_4 = 1'b0, key_6 = 1'b0, key_5 = 1'b0;
    logic [1:0] power_in = 2'd0;
    logic       shell_busy = 1'b0, hit = 1'b0;
    logic [1:0] tank1_life = 2'd3, tank2_life = 2'd3;
    logic       turn, move_right, move_left, fire_start, dmg_tank1, dmg_tank2, game_over;
    logic [1:0] power_q, moves_left, winner;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    tank_turn_sequencer #(
        .TURN_TIMEOUT(4096),
        .MOVE_COOLDOWN(64),
        .MOVES_PER_TURN(3),
        .FLIGHT_TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .key_4(key_4), .key_6(key_6), .key_5(key_5),
        .power_in(power_in), .shell_busy(shell_busy), .hit(hit),
        .tank1_life(tank1_life), .tank2_life(tank2_life),
        .turn(turn), .move_right(move_right), .move_left(move_left),
        .fire_start(fire_start), .power_q(power_q),
        .dmg_tank1(dmg_tank1), .dmg_tank2(dmg_tank2),
        .moves_left(moves_left), .state(state),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic r, input logic l, input logic f);
        key_4 = r; key_6 = l; key_5 = f;
        step(1);
        key_4 = 1'b0; key_6 = 1'b0; key_5 = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(2);
    endtask

    initial begin
        // reset values
        step(3);
        chk("rst_state", 32'(state), 0);
        chk("rst_turn", 32'(turn), 0);
        chk("rst_moves", 32'(moves_left), 3);
        chk("rst_power", 32'(power_q), 0);
        chk("rst_strobes", 32'({move_right, move_left, fire_start, dmg_tank1, dmg_tank2}), 0);
        chk("rst_over", 32'(game_over), 0);
        chk("rst_winner", 32'(winner), 0);
        rst = 1'b0;
        step(2);

        // first move, edge within cooldown, edge after cooldown
        key_4 = 1'b1; step(1);
        chk("mv1_mr", 32'(move_right), 1);
        chk("mv1_moves", 32'(moves_left), 2);
        key_4 = 1'b0; step(1);
        chk("mv1_mr_off", 32'(move_right), 0);
        step(7);
        key_4 = 1'b1; step(1);
        chk("cool_mr", 32'(move_right), 0);
        chk("cool_moves", 32'(moves_left), 2);
        key_4 = 1'b0; step(59);
        key_4 = 1'b1; step(1);
        chk("mv3_mr", 32'(move_right), 1);
        chk("mv3_moves", 32'(moves_left), 1);
        key_4 = 1'b0;

        // budget exhaustion, right-over-left priority, left move
        do_reset;
        pulse(1, 0, 0);
        chk("b1_mr", 32'(move_right), 1);
        chk("b1_moves", 32'(moves_left), 2);
        step(99);
        pulse(1, 1, 0);
        chk("b2_mr", 32'(move_right), 1);
        chk("b2_ml", 32'(move_left), 0);
        chk("b2_moves", 32'(moves_left), 1);
        step(99);
        pulse(0, 1, 0);
        chk("b3_ml", 32'(move_left), 1);
        chk("b3_moves", 32'(moves_left), 0);
        step(99);
        pulse(1, 0, 0);
        chk("b4_mr", 32'(move_right), 0);
        chk("b4_moves", 32'(moves_left), 0);
        chk("b4_state", 32'(state), 0);

        // fire with same-cycle move edge, hit on tank2
        do_reset;
        power_in = 2'd2;
        pulse(1, 0, 1);
        chk("f_state", 32'(state), 1);
        chk("f_fire", 32'(fire_start), 1);
        chk("f_mr", 32'(move_right), 0);
        chk("f_moves", 32'(moves_left), 3);
        chk("f_power", 32'(power_q), 2);
        step(1);
        chk("f_flight", 32'(state), 2);
        chk("f_fire_off", 32'(fire_start), 0);
        shell_busy = 1'b1; step(20);
        chk("f_busy_state", 32'(state), 2);
        shell_busy = 1'b0; hit = 1'b1; step(1);
        chk("f_resolve", 32'(state), 3);
        chk("f_dmg2", 32'(dmg_tank2), 1);
        chk("f_dmg1", 32'(dmg_tank1), 0);
        hit = 1'b0; step(1);
        chk("f_swap", 32'(state), 4);
        chk("f_dmg2_off", 32'(dmg_tank2), 0);
        step(1);
        chk("f_move", 32'(state), 0);
        chk("f_turn", 32'(turn), 1);
        chk("f_moves_reload", 32'(moves_left), 3);
        chk("f_power_hold", 32'(power_q), 2);

        // forced fire after TURN_TIMEOUT cycles, then miss timeout
        step(4095);
        chk("to_state_pre", 32'(state), 0);
        chk("to_fire_pre", 32'(fire_start), 0);
        step(1);
        chk("to_state", 32'(state), 1);
        chk("to_fire", 32'(fire_start), 1);
        hit = 1'b1;
        step(1);
        chk("to_flight", 32'(state), 2);
        step(7);
        chk("to_flight_last", 32'(state), 2);
        step(1);
        chk("to_resolve", 32'(state), 3);
        chk("to_dmg", 32'({dmg_tank1, dmg_tank2}), 0);
        hit = 1'b0;
        step(1);
        chk("to_swap", 32'(state), 4);
        step(1);
        chk("to_move", 32'(state), 0);
        chk("to_turn", 32'(turn), 0);

        // tank2 hit, tank1 life zero in SWAP -> OVER, winner tank2
        power_in = 2'd1;
        pulse(0, 0, 1);
        chk("go_fire", 32'(fire_start), 1);
        chk("go_power", 32'(power_q), 1);
        step(1);
        shell_busy = 1'b1; step(3);
        shell_busy = 1'b0; hit = 1'b1; step(1);
        chk("go_dmg2", 32'(dmg_tank2), 1);
        hit = 1'b0; tank1_life = 2'd0; step(1);
        chk("go_swap", 32'(state), 4);
        chk("go_over_pre", 32'(game_over), 0);
        step(1);
        chk("go_state", 32'(state), 5);
        chk("go_over", 32'(game_over), 1);
        chk("go_winner", 32'(winner), 2);
        chk("go_turn", 32'(turn), 0);
        pulse(1, 0, 0);
        chk("go_key_mr", 32'(move_right), 0);
        pulse(0, 0, 1);
        chk("go_key_fire", 32'(fire_start), 0);
        step(5);
        chk("go_state_hold", 32'(state), 5);
        chk("go_winner_hold", 32'(winner), 2);

        // reset during FLIGHT with a hit pending
        tank1_life = 2'd3;
        do_reset;
        chk("ab_over", 32'(game_over), 0);
        chk("ab_winner", 32'(winner), 0);
        power_in = 2'd3;
        pulse(0, 0, 1);
        step(1);
        shell_busy = 1'b1; step(3);
        shell_busy = 1'b0; hit = 1'b1; rst = 1'b1; step(1);
        chk("ab_state", 32'(state), 0);
        chk("ab_dmg", 32'({dmg_tank1, dmg_tank2}), 0);
        chk("ab_power", 32'(power_q), 0);
        chk("ab_moves", 32'(moves_left), 3);
        chk("ab_fire", 32'(fire_start), 0);
        rst = 1'b0; hit = 1'b0; step(1);
        chk("ab_dmg_after", 32'({dmg_tank1, dmg_tank2}), 0);
        chk("ab_state_after", 32'(state), 0);

        // tank2 life zero, missed shot -> winner tank1
        step(1);
        pulse(0, 0, 1);
        step(1);
        shell_busy = 1'b1; step(2);
        shell_busy = 1'b0; step(1);
        chk("w1_dmg", 32'({dmg_tank1, dmg_tank2}), 0);
        tank2_life = 2'd0; step(2);
        chk("w1_state", 32'(state), 5);
        chk("w1_winner", 32'(winner), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tank_turn_sequencer.md
# tank_turn_sequencer

Turn scheduler for the two-player tank game. Owns the game phase: which tank may act, how many moves it gets, when its shot launches, when the shell datapath has finished, and when damage is applied. It sits between the debounced player keys and the tank/shell state blocks, and replaces their ad-hoc turn toggling with one explicit FSM.

## Interface
Parameters:
- `TURN_TIMEOUT`, default 4096: cycles allowed in MOVE before a forced fire.
- `MOVE_COOLDOWN`, default 64: minimum cycles between two accepted moves.
- `MOVES_PER_TURN`, default 3: move budget reloaded each turn (1..3).
- `FLIGHT_TIMEOUT`, default 8: cycles to wait for `shell_busy` to rise before the shot is declared a miss.

Ports:
- `clk`, in, 1: the single clock; all logic on its rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `key_4`, in, 1: move-right key, level, already synchronised.
- `key_6`, in, 1: move-left key, level, already synchronised.
- `key_5`, in, 1: fire key, level.
- `power_in`, in, 2: requested shell power 0..3.
- `shell_busy`, in, 1: high while the shell datapath animates a shot.
- `hit`, in, 1: shell datapath hit flag; valid on the cycle `shell_busy` falls.
- `tank1_life`, in, 2: current life of tank1.
- `tank2_life`, in, 2: current life of tank2.
- `turn`, out, 1: 0 means tank1 is active, 1 means tank2 is active.
- `move_right`, out, 1: one-cycle move strobe for the active tank.
- `move_left`, out, 1: one-cycle move strobe for the active tank.
- `fire_start`, out, 1: one-cycle launch strobe to the shell datapath.
- `power_q`, out, 2: power latched at launch, stable until the next launch.
- `dmg_tank1`, out, 1: one-cycle life-decrement strobe for tank1.
- `dmg_tank2`, out, 1: one-cycle life-decrement strobe for tank2.
- `moves_left`, out, 2: remaining move budget.
- `state`, out, 3: FSM state code.
- `game_over`, out, 1: high in OVER.
- `winner`, out, 2: 0 = none, 1 = tank1, 2 = tank2.

## Operation
- Keys are rising-edge detected. Previous-key registers reset to 1, so a key held through reset does not act.
- **MOVE (0)**
  - A move is accepted on a key edge when `moves_left`≠0 and the cooldown counter is 0.
  - Right has priority over left when both edge in the same cycle.
  - An accepted move pulses its strobe, decrements `moves_left`, and loads the cooldown with `MOVE_COOLDOWN`-1.
  - A fire edge goes to LAUNCH. A fire edge wins over a same-cycle move edge; no move strobe is issued in that cycle.
  - When the turn timer reaches `TURN_TIMEOUT`-1, go to LAUNCH (forced fire).
- **LAUNCH (1)**
  - Pulse `fire_start` for one cycle and latch `power_q`<=`power_in`.
  - Clear the flight counter and the saw-busy flag. Go to FLIGHT.
- **FLIGHT (2)**
  - `shell_busy`=1 sets saw-busy.
  - When saw-busy=1 and `shell_busy`=0: latch `hit` and go to RESOLVE.
  - When saw-busy=0 and the flight counter reaches `FLIGHT_TIMEOUT`-1: latch hit=0 and go to RESOLVE.
- **RESOLVE (3)**
  - If the latched hit=1: pulse `dmg_tank2` when `turn`=0, or `dmg_tank1` when `turn`=1.
  - Always go to SWAP.
- **SWAP (4)**
  - This state exists so life inputs reflect the damage strobe.
  - If `tank1_life`==0: `winner`=2, go to OVER.
  - Else if `tank2_life`==0: `winner`=1, go to OVER.
  - Otherwise toggle `turn`, set `moves_left`=`MOVES_PER_TURN`, clear the turn timer and cooldown, and go to MOVE.
- **OVER (5)**: terminal. All strobes are 0 and keys are ignored. Only `rst` exits.
- Codes 6 and 7 recover to MOVE on the next cycle, with outputs as in reset.
- Arithmetic widths:
  - Turn timer: width clog2(`TURN_TIMEOUT`). It counts only in MOVE, saturates, and never wraps.
  - Cooldown counter: width clog2(`MOVE_COOLDOWN`). It decrements toward 0 in every state.

## Timing
- Reset values: `turn`=0, `state`=MOVE, `moves_left`=`MOVES_PER_TURN`, `power_q`=0, all strobes 0, `game_over`=0, `winner`=0, all counters 0.
- `rst` asserted mid-flight or mid-resolve aborts immediately, and no damage strobe is issued.
- All outputs are registered.
- Key edge at cycle N → move strobe at N+1.
- Fire key edge at N → LAUNCH at N+1 → `fire_start` at N+1 (Moore strobe on state LAUNCH) → FLIGHT at N+2.
- `shell_busy` falling at cycle F → RESOLVE at F+1 → damage strobe at F+1 → SWAP at F+2 → MOVE or OVER at F+3.
- `game_over` is high for every cycle with state=OVER. `winner` is stable from the OVER entry onward.

## Test plan
- Reset then `key_4` edge: `move_right` pulses once and `moves_left` goes 3→2. A second edge 10 cycles later (within cooldown) is ignored. An edge 70 cycles after the first is accepted and `moves_left`=1.
- Four right edges spaced 100 cycles apart: only 3 strobes; `moves_left` stays 0.
- `key_5` edge with `power_in`=2, `shell_busy` high for 20 cycles, `hit`=1 at the fall: `fire_start` one cycle, `power_q`=2, `dmg_tank2` exactly one pulse, then `turn`=1 and `moves_left`=3.
- No key activity in MOVE: a forced `fire_start` occurs exactly `TURN_TIMEOUT` cycles after MOVE entry. If `shell_busy` never rises, the shot resolves as a miss after `FLIGHT_TIMEOUT` cycles with no damage strobe, then `turn` toggles.
- `tank1_life`=0 presented in SWAP after a tank2 hit: state=OVER, `game_over`=1, `winner`=2. Subsequent key edges produce no strobes.
- `rst` pulsed during FLIGHT with `hit`=1 pending: no `dmg_*` pulse and all outputs return to reset values.
